// File: rtl/mips_pkg.sv
// Shared MIPS32 instruction-format definitions: opcode constants, format
// classification and the field-to-word packer used by the program loader.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

  function automatic fmt_t instr_fmt(input logic [5:0] opcode);
    if (opcode == OP_RTYPE) return FMT_R;
    if (opcode == OP_J || opcode == OP_JAL) return FMT_J;
    return FMT_I;
  endfunction

  // Fields not belonging to the selected format are dropped.
  function automatic logic [31:0] encode_instr(input instr_fields_t f);
    logic [31:0] w;
    case (instr_fmt(f.opcode))
      FMT_R:   w = {f.opcode, f.rs, f.rt, f.rd, f.shamt, f.funct};
      FMT_J:   w = {f.opcode, f.target};
      default: w = {f.opcode, f.rs, f.rt, f.imm};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Two-entry 32-bit synchronous FIFO; head word is always presented on rdata,
// and a push and pop in the same cycle keep the occupancy unchanged.
module enc_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic [1:0]  count
);

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded MIPS32 fields into instruction words and streams them into
// instruction memory at consecutive addresses, bounded by a programmed length.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  written
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        fifo_count;
  logic              push;
  logic              pop;
  logic [31:0]       enc_word;
  instr_fields_t     fields;

  assign fields = '{opcode: opcode, rs: rs, rt: rt, rd: rd, shamt: shamt,
                    funct: funct, imm: imm, target: target};
  assign enc_word = encode_instr(fields);

  assign in_ready = (state == S_RUN) && (remaining != '0) && (fifo_count != 2'd2);
  assign push     = in_valid && in_ready;
  assign mem_we   = (fifo_count != 2'd0);
  assign pop      = mem_we && mem_ready;
  assign mem_addr = ptr;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  enc_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .rdata (mem_wdata),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if ((remaining == '0) && (fifo_count == 2'd0) && !pop) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      ptr       <= '0;
      written   <= '0;
    end else if (state == S_IDLE && start) begin
      ptr       <= base_addr;
      remaining <= prog_len;
      written   <= '0;
    end else begin
      if (push) remaining <= remaining - LEN_W'(1);
      if (pop) begin
        ptr     <= ptr + ADDR_W'(1);
        written <= written + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// loads compared against a behavioural encoding/address model.
module tb_instr_encoder;

  localparam int AW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] prog_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    opcode = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]    funct = '0;
  logic [15:0]   imm = '0;
  logic [25:0]   target = '0;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic [LW-1:0] written;

  logic mem_ready_drv = 1'b1;
  logic rand_ready = 1'b0;
  logic rnd_bit;
  assign mem_ready = rand_ready ? rnd_bit : mem_ready_drv;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .written(written)
  );

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
  } fld_t;

  wr_t log_q[$];
  int  done_cnt = 0;
  int  cyc = 0;

  // Write/done observer: records every write that fires at the next edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst && mem_we && mem_ready) log_q.push_back('{mem_addr, mem_wdata, cyc});
    if (done) done_cnt++;
  end

  function automatic logic [31:0] model_word(input fld_t f);
    logic [31:0] w;
    w = 32'(f.op) << 26;
    if (f.op == 6'd0)
      w = w | (32'(f.rs) << 21) | (32'(f.rt) << 16) | (32'(f.rd) << 11)
            | (32'(f.sh) << 6) | 32'(f.fn);
    else if (f.op == 6'd2 || f.op == 6'd3)
      w = w | 32'(f.tgt);
    else
      w = w | (32'(f.rs) << 21) | (32'(f.rt) << 16) | 32'(f.imm);
    return w;
  endfunction

  function automatic fld_t rand_fields();
    fld_t f;
    case ($urandom_range(0, 3))
      0:       f.op = 6'd0;
      1:       f.op = 6'd2;
      2:       f.op = 6'd3;
      default: f.op = 6'($urandom_range(1, 63));
    endcase
    f.rs = 5'($urandom); f.rt = 5'($urandom); f.rd = 5'($urandom);
    f.sh = 5'($urandom); f.fn = 6'($urandom);
    f.imm = 16'($urandom); f.tgt = 26'($urandom);
    return f;
  endfunction

  task automatic drive_fields(input fld_t f);
    opcode = f.op; rs = f.rs; rt = f.rt; rd = f.rd; shamt = f.sh;
    funct = f.fn; imm = f.imm; target = f.tgt;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    start = 1'b1; base_addr = b; prog_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input fld_t f);
    bit r, ok;
    drive_fields(f);
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_accept: got no in_ready within 100 cycles, expected accept"); end
  endtask

  task automatic wait_done(output logic [LW-1:0] w);
    bit ok;
    ok = 0; w = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; w = written; end
      @(posedge clk); #1;
      if (ok) break;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_timeout: got no done within 300 cycles, expected done"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if ({in_ready, mem_we, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {in_ready, mem_we, busy, done}); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    checks++; if (written !== '0) begin errors++; $display("FAIL reset_written: got %0d expected 0", written); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    fld_t f;
    logic [LW-1:0] w;
    int i0, d0;
    i0 = log_q.size(); d0 = done_cnt;
    mem_ready_drv = 1'b1;
    pulse_start(8'h10, 8'd1);
    f = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd3, sh: 5'd0, fn: 6'h20, imm: 16'hBEEF, tgt: 26'h3FFFFFF};
    send(f);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rtype_latency_we: got %b expected 1", mem_we); end
    checks++; if (mem_wdata !== 32'h00221820) begin errors++; $display("FAIL rtype_word: got %h expected 00221820", mem_wdata); end
    checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL rtype_addr: got %h expected 10", mem_addr); end
    @(posedge clk); #1;
    wait_done(w);
    checks++; if (w !== 8'd1) begin errors++; $display("FAIL rtype_written: got %0d expected 1", w); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rtype_idle: got busy=%b expected 0", busy); end
    checks++; if (log_q.size() - i0 != 1) begin errors++; $display("FAIL rtype_nwrites: got %0d expected 1", log_q.size() - i0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rtype_done_pulses: got %0d expected 1", done_cnt - d0); end
    @(posedge clk); #1;
  endtask

  task automatic test_ij_stream();
    fld_t lw_f, j_f;
    logic [LW-1:0] w;
    int i0;
    i0 = log_q.size();
    lw_f = '{op: 6'h23, rs: 5'd9, rt: 5'd8, rd: 5'd31, sh: 5'd31, fn: 6'h3F, imm: 16'h0004, tgt: '0};
    j_f  = '{op: 6'h02, rs: 5'd7, rt: 5'd7, rd: 5'd7, sh: 5'd7, fn: 6'h07, imm: 16'h7777, tgt: 26'h0100000};
    pulse_start(8'h20, 8'd2);
    send(lw_f);
    send(j_f);
    wait_done(w);
    checks++; if (w !== 8'd2) begin errors++; $display("FAIL ij_written: got %0d expected 2", w); end
    checks++;
    if (log_q.size() - i0 != 2) begin
      errors++; $display("FAIL ij_nwrites: got %0d expected 2", log_q.size() - i0);
    end else begin
      checks++; if (log_q[i0].data !== 32'h8D280004 || log_q[i0].addr !== 8'h20) begin errors++; $display("FAIL ij_lw: got %h@%h expected 8d280004@20", log_q[i0].data, log_q[i0].addr); end
      checks++; if (log_q[i0+1].data !== 32'h08100000 || log_q[i0+1].addr !== 8'h21) begin errors++; $display("FAIL ij_j: got %h@%h expected 08100000@21", log_q[i0+1].data, log_q[i0+1].addr); end
      checks++; if (log_q[i0+1].cyc - log_q[i0].cyc != 1) begin errors++; $display("FAIL ij_back_to_back: got gap %0d expected 1", log_q[i0+1].cyc - log_q[i0].cyc); end
    end
  endtask

  task automatic test_backpressure();
    fld_t bp[4];
    logic [LW-1:0] w;
    bit r;
    int idx, i0;
    for (int k = 0; k < 4; k++) bp[k] = rand_fields();
    i0 = log_q.size();
    mem_ready_drv = 1'b0;
    pulse_start(8'h60, 8'd4);
    idx = 0;
    drive_fields(bp[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        idx++;
        if (idx < 4) drive_fields(bp[idx]);
      end
    end
    in_valid = 1'b0;
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", idx); end
    @(negedge clk);
    checks++; if ({in_ready, mem_we} !== 2'b01) begin errors++; $display("FAIL bp_stall: got ready/we=%b expected 01", {in_ready, mem_we}); end
    @(posedge clk); #1;
    mem_ready_drv = 1'b1;
    for (int k = idx; k < 4; k++) send(bp[k]);
    wait_done(w);
    checks++; if (w !== 8'd4) begin errors++; $display("FAIL bp_written: got %0d expected 4", w); end
    checks++;
    if (log_q.size() - i0 != 4) begin
      errors++; $display("FAIL bp_nwrites: got %0d expected 4", log_q.size() - i0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (log_q[i0+k].data !== model_word(bp[k]) || log_q[i0+k].addr !== 8'(8'h60 + k)) begin
          errors++; $display("FAIL bp_word%0d: got %h@%h expected %h@%h", k, log_q[i0+k].data, log_q[i0+k].addr, model_word(bp[k]), 8'(8'h60 + k));
        end
      end
    end
  endtask

  task automatic test_wrap();
    fld_t a, b;
    logic [LW-1:0] w;
    int i0;
    a = rand_fields(); b = rand_fields();
    i0 = log_q.size();
    pulse_start(8'hFF, 8'd2);
    send(a);
    send(b);
    wait_done(w);
    checks++;
    if (log_q.size() - i0 != 2) begin
      errors++; $display("FAIL wrap_nwrites: got %0d expected 2", log_q.size() - i0);
    end else begin
      checks++; if (log_q[i0].addr !== 8'hFF || log_q[i0].data !== model_word(a)) begin errors++; $display("FAIL wrap_first: got %h@%h expected %h@ff", log_q[i0].data, log_q[i0].addr, model_word(a)); end
      checks++; if (log_q[i0+1].addr !== 8'h00 || log_q[i0+1].data !== model_word(b)) begin errors++; $display("FAIL wrap_second: got %h@%h expected %h@00", log_q[i0+1].data, log_q[i0+1].addr, model_word(b)); end
    end
  endtask

  task automatic test_len0();
    int i0;
    i0 = log_q.size();
    pulse_start(8'h33, 8'd0);
    @(negedge clk);
    checks++; if ({busy, done, in_ready} !== 3'b100) begin errors++; $display("FAIL len0_run: got busy/done/ready=%b expected 100", {busy, done, in_ready}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", done); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL len0_idle: got busy/done=%b expected 00", {busy, done}); end
    checks++; if (log_q.size() != i0 || written !== '0) begin errors++; $display("FAIL len0_nowrite: got %0d writes written=%0d expected 0/0", log_q.size() - i0, written); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    fld_t a, b;
    logic [LW-1:0] w;
    int i0;
    a = rand_fields(); b = rand_fields();
    i0 = log_q.size();
    pulse_start(8'h40, 8'd2);
    pulse_start(8'h80, 8'd5);
    send(a);
    send(b);
    wait_done(w);
    checks++; if (w !== 8'd2) begin errors++; $display("FAIL busystart_written: got %0d expected 2", w); end
    checks++;
    if (log_q.size() - i0 != 2) begin
      errors++; $display("FAIL busystart_nwrites: got %0d expected 2", log_q.size() - i0);
    end else if (log_q[i0].addr !== 8'h40 || log_q[i0+1].addr !== 8'h41) begin
      errors++; $display("FAIL busystart_addr: got %h,%h expected 40,41", log_q[i0].addr, log_q[i0+1].addr);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busystart_idle: got busy=%b expected 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int i0, d0;
    i0 = log_q.size(); d0 = done_cnt;
    mem_ready_drv = 1'b0;
    pulse_start(8'h50, 8'd4);
    send(rand_fields());
    send(rand_fields());
    @(negedge clk);
    checks++; if ({mem_we, in_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_buffered: got we/ready=%b expected 10", {mem_we, in_ready}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({mem_we, busy, done} !== 3'b000 || written !== '0) begin errors++; $display("FAIL rstmid_state: got we/busy/done=%b written=%0d expected 000/0", {mem_we, busy, done}, written); end
    @(posedge clk); #1;
    mem_ready_drv = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (done_cnt != d0 || log_q.size() != i0) begin errors++; $display("FAIL rstmid_silent: got %0d done %0d writes expected 0/0", done_cnt - d0, log_q.size() - i0); end
  endtask

  task automatic test_random();
    fld_t exp_f[$];
    logic [AW-1:0] b;
    logic [LW-1:0] l, w;
    int i0;
    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b = AW'($urandom);
      l = LW'($urandom_range(1, 6));
      exp_f.delete();
      for (int k = 0; k < int'(l); k++) exp_f.push_back(rand_fields());
      i0 = log_q.size();
      pulse_start(b, l);
      for (int k = 0; k < int'(l); k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(exp_f[k]);
      end
      wait_done(w);
      checks++; if (w !== l) begin errors++; $display("FAIL rand%0d_written: got %0d expected %0d", n, w, l); end
      checks++;
      if (log_q.size() - i0 != int'(l)) begin
        errors++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", n, log_q.size() - i0, l);
      end else begin
        for (int k = 0; k < int'(l); k++) begin
          checks++;
          if (log_q[i0+k].data !== model_word(exp_f[k]) || log_q[i0+k].addr !== AW'(int'(b) + k)) begin
            errors++; $display("FAIL rand%0d_word%0d: got %h@%h expected %h@%h", n, k, log_q[i0+k].data, log_q[i0+k].addr, model_word(exp_f[k]), AW'(int'(b) + k));
          end
        end
      end
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ij_stream();
    test_backpressure();
    test_wrap();
    test_len0();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
